control_fsm: RTL and testbench

//  Sequential successor to the combinational instruction decoder.

---
 rtl/control_fsm.sv | 243 ++++++++++++++++++++++++
 tb/tb_control_fsm.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/control_fsm.sv
// control_fsm: sequential instruction controller.
// Decodes the current opcode and stretches multiply, LD and ST over as many
// cycles as they need, holding pc_en low until the instruction retires.
// Conditional relative branches use ZF from the decode cycle.
// An undefined opcode parks the controller in a sticky trap that only reset clears.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | first cycle after reset; every output low
// EXEC      | decode the current opcode; single-cycle ops retire here
// MUL_WAIT  | multiply in flight; cnt counts the cycles still to go
// IN_WAIT   | LD waiting for in_valid
// OUT_WAIT  | ST presenting data, waiting for out_ready
// TRAP      | undefined opcode seen; illegal held high until reset

`ifndef NOP
`define NOP  6'b000_000
`endif
`ifndef ADD
`define ADD  6'b000_001
`endif
`ifndef SUB
`define SUB  6'b000_010
`endif
`ifndef MLT
`define MLT  6'b000_011
`endif
`ifndef ADDI
`define ADDI 6'b001_001
`endif
`ifndef SUBI
`define SUBI 6'b001_010
`endif
`ifndef MLTI
`define MLTI 6'b001_011
`endif
`ifndef LD
`define LD   6'b010_000
`endif
`ifndef ST
`define ST   6'b011_000
`endif
`ifndef JMP
`define JMP  6'b100_000
`endif
`ifndef JZ
`define JZ   6'b101_000
`endif
`ifndef JNZ
`define JNZ  6'b110_000
`endif

module control_fsm #(
    parameter int OPCODE_W   = 6,
    parameter int ALU_W      = 3,
    parameter int MUL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                ZF,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [ALU_W-1:0]    alu_func,
    output logic                pc_en,
    output logic                pc_rel_branch,
    output logic                reg_write,
    output logic                immediate,
    output logic                read_in,
    output logic                write_out,
    output logic                illegal
);

    if (MUL_CYCLES < 1) begin : g_bad_mul_cycles
        $error("control_fsm: MUL_CYCLES must be at least 1");
    end

    localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(`NOP);
    localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(`ADD);
    localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(`SUB);
    localparam logic [OPCODE_W-1:0] OP_MLT  = OPCODE_W'(`MLT);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(`ADDI);
    localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(`SUBI);
    localparam logic [OPCODE_W-1:0] OP_MLTI = OPCODE_W'(`MLTI);
    localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(`LD);
    localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(`ST);
    localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(`JMP);
    localparam logic [OPCODE_W-1:0] OP_JZ   = OPCODE_W'(`JZ);
    localparam logic [OPCODE_W-1:0] OP_JNZ  = OPCODE_W'(`JNZ);

    // Counter holds the number of MUL_WAIT cycles left after the current one.
    localparam int CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int MUL_LOAD = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EXEC     = 3'd1,
        ST_MUL_WAIT = 3'd2,
        ST_IN_WAIT  = 3'd3,
        ST_OUT_WAIT = 3'd4,
        ST_TRAP     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state, counter and output decode from state, opcode and handshakes.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        alu_func      = '0;
        pc_en         = 1'b0;
        pc_rel_branch = 1'b0;
        reg_write     = 1'b0;
        immediate     = 1'b0;
        read_in       = 1'b0;
        write_out     = 1'b0;
        illegal       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_EXEC;
            end

            ST_EXEC: begin
                alu_func = opcode[ALU_W-1:0];
                case (opcode)
                    OP_NOP: begin
                        pc_en = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        reg_write = 1'b1;
                        pc_en     = 1'b1;
                    end
                    OP_ADDI, OP_SUBI: begin
                        reg_write = 1'b1;
                        immediate = 1'b1;
                        pc_en     = 1'b1;
                    end
                    OP_JMP: begin
                        pc_en         = 1'b1;
                        pc_rel_branch = 1'b1;
                    end
                    OP_JZ: begin
                        pc_en         = 1'b1;
                        pc_rel_branch = ZF;
                    end
                    OP_JNZ: begin
                        pc_en         = 1'b1;
                        pc_rel_branch = ~ZF;
                    end
                    OP_MLT, OP_MLTI: begin
                        immediate = (opcode == OP_MLTI);
                        if (MUL_CYCLES == 1) begin
                            reg_write = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(MUL_LOAD);
                            state_d = ST_MUL_WAIT;
                        end
                    end
                    OP_LD: begin
                        in_ready = 1'b1;
                        read_in  = 1'b1;
                        if (in_valid) begin
                            reg_write = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            state_d = ST_IN_WAIT;
                        end
                    end
                    OP_ST: begin
                        out_valid = 1'b1;
                        if (out_ready) begin
                            write_out = 1'b1;
                            pc_en     = 1'b1;
                        end else begin
                            state_d = ST_OUT_WAIT;
                        end
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_MUL_WAIT: begin
                alu_func  = opcode[ALU_W-1:0];
                immediate = (opcode == OP_MLTI);
                if (cnt_q == '0) begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_IN_WAIT: begin
                in_ready = 1'b1;
                read_in  = 1'b1;
                if (in_valid) begin
                    reg_write = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = ST_EXEC;
                end
            end

            ST_OUT_WAIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    write_out = 1'b1;
                    pc_en     = 1'b1;
                    state_d   = ST_EXEC;
                end
            end

            ST_TRAP: begin
                illegal = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and multiply counter registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed scenarios followed by a random instruction
// stream, each cycle compared against a per-instruction timing model.
module tb_control_fsm;

    localparam int M = 3;

    localparam logic [5:0] NOP  = 6'b000_000;
    localparam logic [5:0] ADD  = 6'b000_001;
    localparam logic [5:0] SUB  = 6'b000_010;
    localparam logic [5:0] MLT  = 6'b000_011;
    localparam logic [5:0] ADDI = 6'b001_001;
    localparam logic [5:0] SUBI = 6'b001_010;
    localparam logic [5:0] MLTI = 6'b001_011;
    localparam logic [5:0] LD   = 6'b010_000;
    localparam logic [5:0] ST   = 6'b011_000;
    localparam logic [5:0] JMP  = 6'b100_000;
    localparam logic [5:0] JZ   = 6'b101_000;
    localparam logic [5:0] JNZ  = 6'b110_000;
    localparam logic [5:0] BAD  = 6'h3F;

    localparam int TRAP_LEN = 12;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [5:0] opcode = NOP;
    logic       ZF = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, pc_en, pc_rel_branch, reg_write;
    logic       immediate, read_in, write_out, illegal;
    logic [2:0] alu_func;

    int checks = 0;
    int errors = 0;

    logic [5:0] legal_ops [12] = '{NOP, ADD, SUB, MLT, ADDI, SUBI, MLTI, LD, ST, JMP, JZ, JNZ};

    control_fsm #(.OPCODE_W(6), .ALU_W(3), .MUL_CYCLES(M)) dut (
        .clk(clk), .n_reset(n_reset), .opcode(opcode), .ZF(ZF),
        .in_valid(in_valid), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .alu_func(alu_func), .pc_en(pc_en),
        .pc_rel_branch(pc_rel_branch), .reg_write(reg_write),
        .immediate(immediate), .read_in(read_in), .write_out(write_out),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] observed();
        return {illegal, write_out, read_in, immediate, reg_write, pc_rel_branch,
                pc_en, out_valid, in_ready, alu_func};
    endfunction

    // Expected outputs for cycle k of an instruction lasting len cycles.
    function automatic logic [11:0] model(input logic [5:0] op, input int k,
                                          input int len, input logic zf);
        logic ill = 0, wo = 0, ri = 0, imm = 0, rw = 0, br = 0, pc = 0, ov = 0, ir = 0;
        logic [2:0] alu = op[2:0];
        logic last = (k == len - 1);
        case (op)
            NOP:       pc = 1;
            ADD, SUB:  begin rw = 1; pc = 1; end
            ADDI, SUBI: begin rw = 1; imm = 1; pc = 1; end
            JMP:       begin pc = 1; br = 1; end
            JZ:        begin pc = 1; br = zf; end
            JNZ:       begin pc = 1; br = !zf; end
            MLT, MLTI: begin imm = (op == MLTI); rw = last; pc = last; end
            LD: begin
                ir = 1; ri = 1; rw = last; pc = last;
                if (k != 0) alu = 0;
            end
            ST: begin
                ov = 1; wo = last; pc = last;
                if (k != 0) alu = 0;
            end
            default: begin
                if (k != 0) begin alu = 0; ill = 1; end
            end
        endcase
        return {ill, wo, ri, imm, rw, br, pc, ov, ir, alu};
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%03h expected=%03h", tag, obs, exp);
        end
    endtask

    // Drive one instruction; d is the handshake delay for LD/ST, zf_mode<0 means random ZF.
    task automatic run_instr(input logic [5:0] op, input int d, input int zf_mode);
        int len;
        bit is_legal = 0;
        foreach (legal_ops[i]) if (legal_ops[i] == op) is_legal = 1;
        if (!is_legal)                 len = TRAP_LEN;
        else if (op == MLT || op == MLTI) len = M;
        else if (op == LD || op == ST) len = d + 1;
        else                           len = 1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) opcode = op;
            ZF = (zf_mode < 0) ? 1'($urandom) : 1'(zf_mode);
            in_valid  = (op == LD) ? (k == d) : 1'($urandom);
            out_ready = (op == ST) ? (k == d) : 1'($urandom);
            #1;
            check($sformatf("op%02h_k%0d_of%0d", op, k, len), observed(),
                  model(op, k, len, ZF));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 n_reset = 0;
        #1 check("reset_asserted", observed(), 12'h000);
        @(negedge clk);
        n_reset = 1;
        #1 check("idle_after_release", observed(), 12'h000);
    endtask

    initial begin
        // Reset release, then ADD decodes one cycle later.
        opcode = ADD;
        #22;
        check("in_reset", observed(), 12'h000);
        @(negedge clk);
        n_reset = 1;
        #1 check("cycle0_idle", observed(), 12'h000);
        run_instr(ADD, 0, -1);

        run_instr(MLTI, 0, -1);
        run_instr(LD, 4, -1);
        run_instr(ST, 0, -1);
        run_instr(ST, 3, -1);
        run_instr(JZ, 0, 0);
        run_instr(JZ, 0, 1);
        run_instr(JNZ, 0, 1);
        run_instr(JNZ, 0, 0);
        run_instr(MLT, 0, -1);

        // Sticky trap, cleared only by reset.
        run_instr(BAD, 0, -1);
        do_reset();
        run_instr(MLT, 0, -1);

        // Reset pulse while the multiply is in MUL_WAIT.
        @(negedge clk);
        opcode = MLT;
        #1 check("mul_abort_k0", observed(), model(MLT, 0, M, ZF));
        @(negedge clk);
        #1 check("mul_abort_k1", observed(), model(MLT, 1, M, ZF));
        n_reset = 0;
        #1 check("mul_abort_reset", observed(), 12'h000);
        @(negedge clk);
        n_reset = 1;
        #1 check("mul_abort_idle", observed(), 12'h000);
        run_instr(MLTI, 0, -1);

        // Random instruction stream with occasional illegal opcodes.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                run_instr(6'($urandom_range(52, 63)), 0, -1);
                do_reset();
            end else begin
                run_instr(legal_ops[$urandom_range(0, 11)], $urandom_range(0, 4), -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
